univ_shift_reg_re: RTL
======================

UNIV_SHIFT_REG_RE -- requirements
Module: univ_shift_reg_re

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter ROTATE, default 0: 0 = shift modes take serial inputs; 1 = shift modes rotate.
REQ-003 C  input  1  clock; all state changes on rising edge of C.
REQ-004 RE  input  1  reset, asynchronous, active-high.
REQ-005 EN  input  1  clock enable; 0 = hold regardless of MODE.
REQ-006 MODE  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 D  input  WIDTH  parallel load data.
REQ-008 SIR  input  1  serial in for right shift; enters at MSB.
REQ-009 SIL  input  1  serial in for left shift; enters at LSB.
REQ-010 Q  output  WIDTH  register contents.
REQ-011 Qnot  output  WIDTH  bitwise complement of Q, always.
REQ-012 SOR  output  1  serial out right, equal to Q[0].
REQ-013 SOL  output  1  serial out left, equal to Q[WIDTH-1].

Function
REQ-014 State is a single WIDTH-bit register; Qnot, SOR and SOL are combinational from it, with no extra cycle.
REQ-015 Update only on a rising edge of C with RE=0 and EN=1; otherwise the register holds.
REQ-016 MODE 00: Q(next) = Q.
REQ-017 MODE 01, ROTATE=0: Q(next) = {SIR, Q[WIDTH-1:1]}.
REQ-018 MODE 01, ROTATE=1: Q(next) = {Q[0], Q[WIDTH-1:1]}; SIR ignored.
REQ-019 MODE 10, ROTATE=0: Q(next) = {Q[WIDTH-2:0], SIL}.
REQ-020 MODE 10, ROTATE=1: Q(next) = {Q[WIDTH-2:0], Q[WIDTH-1]}; SIL ignored.
REQ-021 MODE 11: Q(next) = D.
REQ-022 Latency: one edge; the new value is visible on Q, Qnot, SOR and SOL immediately after the capturing edge.
REQ-023 Inputs D, SIR, SIL, MODE and EN are sampled at the rising edge only; changes between edges have no effect.
REQ-024 Serial inputs are taken before the shift; SOR/SOL after an edge reflect the post-shift register.
REQ-025 After WIDTH consecutive right shifts with ROTATE=0, Q equals the last WIDTH SIR bits; the first bit shifted in sits at Q[0].
REQ-026 With ROTATE=1, WIDTH consecutive shifts in one direction return Q to its starting value.
REQ-027 An X or Z on MODE while EN=1 is a protocol violation; a simulation assertion SHALL flag it.

Reset
REQ-028 RE=1 forces Q = 0, Qnot = all ones, SOR = 0 and SOL = 0 immediately, without waiting for a clock edge.
REQ-029 While RE=1, rising edges of C have no effect regardless of EN and MODE.
REQ-030 RE asserted mid-operation, including between edges of a shift sequence, discards all state.
REQ-031 The first capture after reset is the first rising edge of C at which RE is sampled 0.
REQ-032 If RE falls coincident with a rising edge of C, that edge does not capture.

Verification (WIDTH=8)
REQ-033 Async reset: load 8'hA5, then raise RE mid-cycle with C stable -> Q=8'h00 and Qnot=8'hFF before the next edge; edges during RE=1 leave Q=8'h00.
REQ-034 Load/hold: MODE=11, D=8'h3C, one edge -> Q=8'h3C, Qnot=8'hC3; then MODE=00 for 5 edges -> Q stays 8'h3C; EN=0 with MODE=11, D=8'hFF -> Q stays 8'h3C.
REQ-035 Serial right, ROTATE=0: from Q=0, shift right 8 edges with SIR sequence 1,0,1,1,0,0,1,0 -> Q=8'h4D; SOR after the first edge = 0.
REQ-036 Serial left, ROTATE=0: load 8'h81, shift left 1 edge with SIL=0 -> Q=8'h02; SOL before that edge = 1.
REQ-037 Rotate, ROTATE=1: load 8'h96, rotate right 1 edge -> 8'h4B; rotate left 8 edges -> 8'h4B; SIR/SIL toggling has no effect.
REQ-038 Reset release: deassert RE on a rising edge with MODE=11, D=8'h55 -> Q=8'h00 after that edge and 8'h55 after the next edge.

Source files
------------

// File: rtl/univ_shift_reg_re.sv
// univ_shift_reg_re
// Universal shift register: hold, shift right, shift left, parallel load.
// With ROTATE=1 the shift modes recirculate the bit that falls off the end
// instead of taking SIR/SIL.
//
// Ports
//   C     in   1      clock, rising edge
//   RE    in   1      asynchronous reset, active high (Q -> 0)
//   EN    in   1      clock enable, 0 = hold
//   MODE  in   2      00 hold, 01 shift right, 10 shift left, 11 load D
//   D     in   WIDTH  parallel load data
//   SIR   in   1      serial in for right shift (enters at MSB)
//   SIL   in   1      serial in for left shift (enters at LSB)
//   Q     out  WIDTH  register contents
//   Qnot  out  WIDTH  ~Q
//   SOR   out  1      Q[0]
//   SOL   out  1      Q[WIDTH-1]

module univ_shift_reg_re #(
  parameter int WIDTH  = 8,
  parameter int ROTATE = 0
) (
  input  logic             C,
  input  logic             RE,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIR,
  input  logic             SIL,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qnot,
  output logic             SOR,
  output logic             SOL
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("univ_shift_reg_re: WIDTH must be in 2..64");
  end

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_sin_r;
  logic             w_sin_l;

  // In rotate builds the serial inputs are ignored and the end bits wrap.
  assign w_sin_r = (ROTATE != 0) ? r_q[0]       : SIR;
  assign w_sin_l = (ROTATE != 0) ? r_q[WIDTH-1] : SIL;

  always_comb begin
    w_next = r_q;
    case (MODE)
      2'b01:   w_next = {w_sin_r, r_q[WIDTH-1:1]};
      2'b10:   w_next = {r_q[WIDTH-2:0], w_sin_l};
      2'b11:   w_next = D;
      default: w_next = r_q;
    endcase
  end

  always_ff @(posedge C or posedge RE) begin
    if (RE) begin
      r_q <= '0;
    end else if (EN) begin
      r_q <= w_next;
    end
  end

  assign Q    = r_q;
  assign Qnot = ~r_q;
  assign SOR  = r_q[0];
  assign SOL  = r_q[WIDTH-1];

`ifndef SYNTHESIS
  a_mode_known: assert property (@(posedge C) disable iff (RE) EN |-> !$isunknown(MODE))
    else $error("univ_shift_reg_re: MODE unknown while EN=1");
`endif

endmodule
